// File: rtl/band_gain_ramp_ctrl_if.sv
// band_gain_ramp_ctrl_if: host write/commit handshake for the band gain ramp controller
interface band_gain_ramp_ctrl_if #(parameter int COEF_W = 3);
  logic              wr_valid;
  logic              wr_ready;
  logic [2:0]        wr_band;
  logic [COEF_W-1:0] wr_gain;
  logic              commit_req;
  logic              commit_done;
  modport master (output wr_valid, wr_band, wr_gain, commit_req, input wr_ready, commit_done);
  modport slave  (input wr_valid, wr_band, wr_gain, commit_req, output wr_ready, commit_done);
endinterface

// File: rtl/band_gain_ramp_ctrl.sv
// band_gain_ramp_ctrl: shadowed per-band gains, sample-aligned commit, 1-LSB zipper-free ramp
module band_gain_ramp_ctrl #(
  parameter int COEF_W       = 3,
  parameter int RAMP_DIV     = 4,
  parameter int DEFAULT_GAIN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic                mute,
  band_gain_ramp_ctrl_if.slave host,
  output logic                busy,
  output logic [0:COEF_W-1]   amp_coef_1,
  output logic [0:COEF_W-1]   amp_coef_2,
  output logic [0:COEF_W-1]   amp_coef_3,
  output logic [0:COEF_W-1]   amp_coef_4,
  output logic [0:COEF_W-1]   amp_coef_5,
  output logic [0:COEF_W-1]   amp_coef_6,
  output logic [0:COEF_W-1]   amp_coef_7,
  output logic [0:COEF_W-1]   amp_coef_8
);
  localparam int DW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [COEF_W-1:0] GAIN0 = COEF_W'(DEFAULT_GAIN);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t            state_q, state_d;
  logic [DW-1:0]     div_cnt_q, div_cnt_d;
  logic              commit_pend_q, commit_pend_d;
  logic              commit_done_q, commit_done_d;
  logic [COEF_W-1:0] shadow_q [8], shadow_d [8];
  logic [COEF_W-1:0] target_q [8], target_d [8];
  logic [COEF_W-1:0] live_q [8], live_d [8];
  logic [COEF_W-1:0] eff [8];
  logic              wr_fire, copy, step, mismatch, step_eq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      commit_pend_q <= 1'b0;
      commit_done_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= GAIN0;
        target_q[i] <= GAIN0;
        live_q[i]   <= GAIN0;
      end
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      commit_pend_q <= commit_pend_d;
      commit_done_q <= commit_done_d;
      shadow_q      <= shadow_d;
      target_q      <= target_d;
      live_q        <= live_d;
    end
  end
  // Datapath: the commit copy and each ramp step both fire only on a sample_tick edge
  always_comb begin
    wr_fire       = host.wr_valid && !commit_pend_q;
    copy          = commit_pend_q && sample_tick;
    step          = state_q == RAMP && sample_tick && div_cnt_q == DW'(RAMP_DIV - 1);
    commit_pend_d = copy ? 1'b0 : (host.commit_req || commit_pend_q);
    commit_done_d = copy;
    shadow_d      = shadow_q;
    if (wr_fire) shadow_d[host.wr_band] = host.wr_gain;
    target_d      = copy ? shadow_q : target_q;
    mismatch      = 1'b0;
    step_eq       = 1'b1;
    for (int i = 0; i < 8; i++) begin
      eff[i]    = mute ? '0 : target_q[i];
      live_d[i] = (step && live_q[i] < eff[i]) ? live_q[i] + 1'b1 :
                  (step && live_q[i] > eff[i]) ? live_q[i] - 1'b1 : live_q[i];
      mismatch  = mismatch || live_q[i] != eff[i];
      step_eq   = step_eq && live_d[i] == eff[i];
    end
  end
  always_comb begin
    state_d   = (state_q == IDLE) ? (mismatch ? RAMP : IDLE)
                                  : ((!mismatch || (step && step_eq)) ? IDLE : RAMP);
    div_cnt_d = (state_d == IDLE || step) ? '0 :
                (state_q == RAMP && sample_tick) ? DW'(div_cnt_q + 1'b1) : div_cnt_q;
  end
  always_comb begin
    busy             = state_q == RAMP;
    host.wr_ready    = !commit_pend_q;
    host.commit_done = commit_done_q;
    amp_coef_1       = live_q[0];
    amp_coef_2       = live_q[1];
    amp_coef_3       = live_q[2];
    amp_coef_4       = live_q[3];
    amp_coef_5       = live_q[4];
    amp_coef_6       = live_q[5];
    amp_coef_7       = live_q[6];
    amp_coef_8       = live_q[7];
  end
endmodule

// File: tb/tb_band_gain_ramp_ctrl.sv
// tb_band_gain_ramp_ctrl: directed checks of write/commit/ramp/mute/reset with RAMP_DIV=2
module tb_band_gain_ramp_ctrl;
  logic clk = 1'b0;
  logic rst_n, sample_tick, mute, busy;
  logic [0:2] c1, c2, c3, c4, c5, c6, c7, c8;
  logic [2:0] amp [8];
  int n_cmp = 0;
  int n_err = 0;
  band_gain_ramp_ctrl_if #(.COEF_W(3)) bus ();
  band_gain_ramp_ctrl #(.COEF_W(3), .RAMP_DIV(2), .DEFAULT_GAIN(1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .mute(mute), .host(bus.slave),
    .busy(busy), .amp_coef_1(c1), .amp_coef_2(c2), .amp_coef_3(c3), .amp_coef_4(c4),
    .amp_coef_5(c5), .amp_coef_6(c6), .amp_coef_7(c7), .amp_coef_8(c8)
  );
  always #5 clk = ~clk;
  assign amp[0] = c1;
  assign amp[1] = c2;
  assign amp[2] = c3;
  assign amp[3] = c4;
  assign amp[4] = c5;
  assign amp[5] = c6;
  assign amp[6] = c7;
  assign amp[7] = c8;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int v);
    for (int i = 0; i < 8; i++) chk($sformatf("%s amp_coef_%0d", tag, i + 1), 32'(amp[i]), 32'(v));
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    repeat (2) cyc();
  endtask
  task automatic write(input int b, input int g);
    bus.wr_valid = 1'b1;
    bus.wr_band  = 3'(b);
    bus.wr_gain  = 3'(g);
    cyc();
    bus.wr_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; mute = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_band = '0; bus.wr_gain = '0; bus.commit_req = 1'b0;
    repeat (2) cyc();
    chk_all("reset", 1);
    chk("reset wr_ready", 32'(bus.wr_ready), 1);
    chk("reset busy", 32'(busy), 0);
    chk("reset commit_done", 32'(bus.commit_done), 0);
    rst_n = 1'b1;
    cyc();
    // uncommitted write must not reach the live gains
    write(3, 5);
    repeat (10) tick();
    chk("nocommit amp_coef_4", 32'(c4), 1);
    chk("nocommit busy", 32'(busy), 0);
    write(3, 1);
    // write in the commit_req cycle is part of the commit
    bus.wr_valid = 1'b1; bus.wr_band = 3'd0; bus.wr_gain = 3'd4; bus.commit_req = 1'b1;
    cyc();
    bus.wr_valid = 1'b0; bus.commit_req = 1'b0;
    chk("pending wr_ready", 32'(bus.wr_ready), 0);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk("t1 commit_done", 32'(bus.commit_done), 1);
    chk("t1 busy", 32'(busy), 0);
    cyc();
    chk("t1+1 busy", 32'(busy), 1);
    chk("t1+1 commit_done", 32'(bus.commit_done), 0);
    tick();
    chk("t2 amp_coef_1", 32'(c1), 1);
    tick();
    chk("t3 amp_coef_1", 32'(c1), 2);
    tick();
    chk("t4 amp_coef_1", 32'(c1), 2);
    tick();
    chk("t5 amp_coef_1", 32'(c1), 3);
    tick();
    chk("t6 amp_coef_1", 32'(c1), 3);
    chk("t6 busy", 32'(busy), 1);
    tick();
    chk("t7 amp_coef_1", 32'(c1), 4);
    chk("t7 busy", 32'(busy), 0);
    chk("t7 amp_coef_2", 32'(c2), 1);
    // write held while a commit is pending waits until after the copy
    bus.commit_req = 1'b1;
    cyc();
    bus.commit_req = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_band = 3'd1; bus.wr_gain = 3'd4;
    cyc();
    chk("blocked wr_ready", 32'(bus.wr_ready), 0);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk("copy2 commit_done", 32'(bus.commit_done), 1);
    chk("copy2 wr_ready", 32'(bus.wr_ready), 1);
    cyc();
    bus.wr_valid = 1'b0;
    cyc();
    chk("blocked write not copied busy", 32'(busy), 0);
    for (int b = 2; b < 8; b++) write(b, 4);
    bus.commit_req = 1'b1;
    cyc();
    bus.commit_req = 1'b0;
    repeat (8) tick();
    chk_all("all4", 4);
    chk("all4 busy", 32'(busy), 0);
    // mute ramps down, unmute mid-ramp redirects back up
    mute = 1'b1;
    repeat (2) cyc();
    chk("mute busy", 32'(busy), 1);
    repeat (2) tick();
    chk_all("mute step1", 3);
    repeat (2) tick();
    chk_all("mute step2", 2);
    mute = 1'b0;
    tick();
    chk("unmute hold amp_coef_8", 32'(c8), 2);
    tick();
    chk_all("unmute step1", 3);
    repeat (2) tick();
    chk_all("unmute step2", 4);
    chk("unmute busy", 32'(busy), 0);
    mute = 1'b1;
    cyc();
    repeat (8) tick();
    chk_all("mute zero", 0);
    chk("mute zero busy", 32'(busy), 0);
    repeat (4) tick();
    chk_all("mute floor", 0);
    mute = 1'b0;
    cyc();
    repeat (8) tick();
    chk_all("restore", 4);
    // commit_req on a tick copies on the next tick only
    write(0, 1);
    bus.commit_req = 1'b1; sample_tick = 1'b1;
    cyc();
    bus.commit_req = 1'b0; sample_tick = 1'b0;
    chk("coinc commit_done", 32'(bus.commit_done), 0);
    chk("coinc wr_ready", 32'(bus.wr_ready), 0);
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk("coinc next commit_done", 32'(bus.commit_done), 1);
    cyc();
    repeat (2) tick();
    chk("down amp_coef_1", 32'(c1), 3);
    chk("down amp_coef_2", 32'(c2), 4);
    chk("down busy", 32'(busy), 1);
    write(0, 7);
    bus.commit_req = 1'b1;
    cyc();
    bus.commit_req = 1'b0;
    chk("prereset wr_ready", 32'(bus.wr_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async reset", 1);
    chk("async reset wr_ready", 32'(bus.wr_ready), 1);
    chk("async reset busy", 32'(busy), 0);
    cyc();
    rst_n = 1'b1;
    repeat (6) tick();
    chk_all("lost commit", 1);
    chk("lost commit busy", 32'(busy), 0);
    chk("lost commit wr_ready", 32'(bus.wr_ready), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
